// File: rtl/addsub_share_arbiter.sv
// Two requesters share one 4-bit adder/subtractor through a round-robin arbiter.
// Each granted operation holds its grant for three cycles, and Done is pulsed in the last of them.
module addsub_share_arbiter (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req_A,
  input  logic       Sub_A,
  input  logic [3:0] X_A,
  input  logic [3:0] Y_A,
  input  logic       Req_B,
  input  logic       Sub_B,
  input  logic [3:0] X_B,
  input  logic [3:0] Y_B,
  output logic       Grant_A,
  output logic       Grant_B,
  output logic       Done_A,
  output logic       Done_B,
  output logic [3:0] Result,
  output logic       Carry,
  output logic       Overflow,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_n;
  logic       exec_late_q, exec_late_n;
  logic       ptr_b_q, ptr_b_n;
  logic       side_b_q, side_b_n;
  logic       sub_q, sub_n;
  logic [3:0] x_q, x_n;
  logic [3:0] y_q, y_n;
  logic       grant_a_n, grant_b_n;
  logic       done_a_n, done_b_n;
  logic [3:0] result_n;
  logic       carry_n, overflow_n;
  logic       win_b;
  logic [3:0] y_eff;
  logic [4:0] sum;

  // Shared datapath: subtraction is X + ~Y + 1, so Carry=1 means no borrow
  assign y_eff = sub_q ? ~y_q : y_q;
  assign sum   = {1'b0, x_q} + {1'b0, y_eff} + {4'b0000, sub_q};
  assign win_b = Req_B & (~Req_A | ptr_b_q);

  always_comb begin
    state_n     = state_q;
    exec_late_n = exec_late_q;
    ptr_b_n     = ptr_b_q;
    side_b_n    = side_b_q;
    sub_n       = sub_q;
    x_n         = x_q;
    y_n         = y_q;
    grant_a_n   = Grant_A;
    grant_b_n   = Grant_B;
    result_n    = Result;
    carry_n     = Carry;
    overflow_n  = Overflow;
    case (state_q)
      IDLE: begin
        if (Req_A || Req_B) begin
          side_b_n    = win_b;
          sub_n       = win_b ? Sub_B : Sub_A;
          x_n         = win_b ? X_B : X_A;
          y_n         = win_b ? Y_B : Y_A;
          grant_a_n   = ~win_b;
          grant_b_n   = win_b;
          exec_late_n = 1'b0;
          state_n     = EXEC;
        end
      end
      // EXEC spans two cycles so the grant covers three cycles in total
      EXEC: begin
        if (!exec_late_q) begin
          exec_late_n = 1'b1;
        end else begin
          result_n   = sum[3:0];
          carry_n    = sum[4];
          overflow_n = (x_q[3] == y_eff[3]) && (sum[3] != x_q[3]);
          state_n    = RESP;
        end
      end
      RESP: begin
        grant_a_n = 1'b0;
        grant_b_n = 1'b0;
        ptr_b_n   = ~side_b_q;
        state_n   = IDLE;
      end
      default: begin
        state_n   = IDLE;
        grant_a_n = 1'b0;
        grant_b_n = 1'b0;
      end
    endcase
    done_a_n = (state_n == RESP) && !side_b_n;
    done_b_n = (state_n == RESP) && side_b_n;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      exec_late_q <= 1'b0;
      ptr_b_q     <= 1'b0;
      side_b_q    <= 1'b0;
      sub_q       <= 1'b0;
      x_q         <= 4'd0;
      y_q         <= 4'd0;
      Grant_A     <= 1'b0;
      Grant_B     <= 1'b0;
      Done_A      <= 1'b0;
      Done_B      <= 1'b0;
      Result      <= 4'd0;
      Carry       <= 1'b0;
      Overflow    <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      exec_late_q <= exec_late_n;
      ptr_b_q     <= ptr_b_n;
      side_b_q    <= side_b_n;
      sub_q       <= sub_n;
      x_q         <= x_n;
      y_q         <= y_n;
      Grant_A     <= grant_a_n;
      Grant_B     <= grant_b_n;
      Done_A      <= done_a_n;
      Done_B      <= done_b_n;
      Result      <= result_n;
      Carry       <= carry_n;
      Overflow    <= overflow_n;
      Busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Bench for addsub_share_arbiter: fixed vectors, reset/alternation sequences and a random run,
// all compared against a transaction-level model of the arbiter.
module tb_addsub_share_arbiter;

  logic       Clock = 1'b0;
  logic       Reset, Req_A, Sub_A, Req_B, Sub_B;
  logic [3:0] X_A, Y_A, X_B, Y_B;
  logic       Grant_A, Grant_B, Done_A, Done_B, Carry, Overflow, Busy;
  logic [3:0] Result;

  int vectors = 0;
  int miscompares = 0;

  int         m_rem;
  logic       m_side, m_ptr, m_sub, m_carry, m_ovf;
  logic [3:0] m_x, m_y, m_res;

  typedef struct {
    logic       side;
    logic       sub;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] res;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t tbl[5];
  logic done_order[$];

  addsub_share_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .Req_A(Req_A), .Sub_A(Sub_A), .X_A(X_A), .Y_A(Y_A),
    .Req_B(Req_B), .Sub_B(Sub_B), .X_B(X_B), .Y_B(Y_B),
    .Grant_A(Grant_A), .Grant_B(Grant_B), .Done_A(Done_A), .Done_B(Done_B),
    .Result(Result), .Carry(Carry), .Overflow(Overflow), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // One operation: grant for three cycles, result computed with plain integer arithmetic
  task automatic modelEdge();
    int xs, ys, sx, sy, r, sr;
    if (Reset) begin
      m_rem = 0; m_ptr = 0; m_side = 0; m_res = 0; m_carry = 0; m_ovf = 0;
    end else if (m_rem == 0) begin
      if (Req_A || Req_B) begin
        m_side = (Req_A && Req_B) ? m_ptr : Req_B;
        m_sub  = m_side ? Sub_B : Sub_A;
        m_x    = m_side ? X_B : X_A;
        m_y    = m_side ? Y_B : Y_A;
        m_rem  = 3;
      end
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 1) begin
        xs = int'(m_x); ys = int'(m_y);
        sx = (xs > 7) ? xs - 16 : xs;
        sy = (ys > 7) ? ys - 16 : ys;
        r  = m_sub ? xs - ys : xs + ys;
        sr = m_sub ? sx - sy : sx + sy;
        m_res   = 4'(r);
        m_carry = m_sub ? (xs >= ys) : (r > 15);
        m_ovf   = (sr > 7) || (sr < -8);
      end
      if (m_rem == 0) m_ptr = ~m_side;
    end
  endtask

  task automatic checkOutput(input string name);
    logic [10:0] act, exp;
    act = {Grant_A, Grant_B, Done_A, Done_B, Result, Carry, Overflow, Busy};
    exp = {(m_rem > 0) && !m_side, (m_rem > 0) && m_side,
           (m_rem == 1) && !m_side, (m_rem == 1) && m_side,
           m_res, m_carry, m_ovf, m_rem > 0};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %b expected %b (GA GB DA DB Result C V Busy)",
               name, $time, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input logic [10:0] act, input logic [10:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input string name);
    modelEdge();
    @(posedge Clock);
    #1;
    checkOutput(name);
  endtask

  initial begin
    tbl[0] = '{0, 0, 4'd3,  4'd4, 4'd7,  0, 0};
    tbl[1] = '{1, 1, 4'd2,  4'd5, 4'd13, 0, 0};
    tbl[2] = '{1, 0, 4'd7,  4'd1, 4'd8,  0, 1};
    tbl[3] = '{0, 0, 4'd15, 4'd1, 4'd0,  1, 0};
    tbl[4] = '{0, 1, 4'd8,  4'd1, 4'd7,  1, 1};

    Reset = 1; Req_A = 0; Req_B = 0; Sub_A = 0; Sub_B = 0;
    X_A = 0; Y_A = 0; X_B = 0; Y_B = 0;
    m_rem = 0; m_ptr = 0; m_side = 0; m_sub = 0; m_x = 0; m_y = 0;
    m_res = 0; m_carry = 0; m_ovf = 0;
    applyStimulus("reset");
    applyStimulus("reset");
    checkValue("reset_outputs", {Grant_A, Grant_B, Done_A, Done_B, Result, Carry, Overflow, Busy}, 11'd0);
    Reset = 0;

    // Directed single-requester vectors; operands are scrambled after the grant
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].side) begin
        Req_B = 1; Sub_B = tbl[i].sub; X_B = tbl[i].x; Y_B = tbl[i].y;
      end else begin
        Req_A = 1; Sub_A = tbl[i].sub; X_A = tbl[i].x; Y_A = tbl[i].y;
      end
      applyStimulus("tbl_grant");
      Req_A = 0; Req_B = 0; X_A = 4'($urandom_range(15)); X_B = 4'($urandom_range(15));
      applyStimulus("tbl_exec");
      applyStimulus("tbl_exec");
      checkValue("tbl_result",
                 {7'd0, Done_A, Done_B, Result[3:2]},
                 {7'd0, !tbl[i].side, tbl[i].side, tbl[i].res[3:2]});
      checkValue("tbl_flags", {5'd0, Result, Carry, Overflow},
                 {5'd0, tbl[i].res, tbl[i].carry, tbl[i].ovf});
      applyStimulus("tbl_idle");
      checkValue("tbl_idle_busy", {10'd0, Busy}, 11'd0);
    end

    // Reset during EXEC aborts; a simultaneous request afterwards goes to A
    Req_B = 1; Sub_B = 0; X_B = 4'd5; Y_B = 4'd6;
    applyStimulus("abort_grant");
    Req_B = 0;
    Reset = 1;
    applyStimulus("abort_reset");
    checkValue("abort_zero", {Grant_A, Grant_B, Done_A, Done_B, Result, Carry, Overflow, Busy}, 11'd0);
    Reset = 0; Req_A = 1; Req_B = 1;
    applyStimulus("abort_regrant");
    checkValue("abort_grant_a", {9'd0, Grant_A, Grant_B}, 11'b10);
    for (int i = 0; i < 3; i++) applyStimulus("abort_finish");

    // Both held from reset: completions alternate A, B, A, B
    Reset = 1;
    applyStimulus("alt_reset");
    Reset = 0;
    done_order.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus("alt_run");
      if (Done_A) done_order.push_back(1'b0);
      if (Done_B) done_order.push_back(1'b1);
    end
    checkValue("alt_count", 11'(done_order.size()), 11'd4);
    if (done_order.size() >= 4)
      checkValue("alt_order", {7'd0, done_order[0], done_order[1], done_order[2], done_order[3]},
                 11'b0101);
    Req_A = 0; Req_B = 0;
    for (int i = 0; i < 4; i++) applyStimulus("alt_drain");

    // Random traffic, including occasional resets mid-operation
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(39) == 0);
      Req_A = $urandom_range(1) == 1; Req_B = $urandom_range(1) == 1;
      Sub_A = $urandom_range(1) == 1; Sub_B = $urandom_range(1) == 1;
      X_A = 4'($urandom_range(15)); Y_A = 4'($urandom_range(15));
      X_B = 4'($urandom_range(15)); Y_B = 4'($urandom_range(15));
      applyStimulus("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
